deser1x16: RTL

Serial-to-parallel deserializer and 1-to-16 bit demultiplexer: the receive-side counterpart of the 16:1 select path. Serial bits arrive one per accepted cycle, LSB first. Each bit is steered by an internal 4-bit index into position `k` of a 16-bit assembly word, so index `k` maps to bit `k`, the inverse of the mux's `s = k` selecting `i[k]`. A completed word is presented through a valid/ready output register with overrun detection.

---
 rtl/deser_pkg.sv | 13 +
 rtl/demux1x16.sv | 17 +
 rtl/deser1x16.sv | 79 +++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared constants and types for the 1x16 deserializer and its write-enable decoder.
package deser_pkg;

    localparam int WIDTH = 16;
    localparam int IDX_W = 4;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/demux1x16.sv
// One-hot write-enable decoder: index k enables assembly bit k, the inverse of a 16:1 select.
module demux1x16
    import deser_pkg::*;
(
    input  idx_t  idx,
    input  logic  en,
    output word_t we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/deser1x16.sv
// Serial-to-parallel deserializer: LSB-first bits assembled into 16-bit words,
// presented through a valid/ready output register with overrun detection.
module deser1x16
    import deser_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [IDX_W-1:0] sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    idx_t  wr_idx;
    word_t we;
    word_t assembly;
    logic  state;
    logic  state_nxt;
    logic  complete;
    logic  load;
    logic  drop;

    // A start of frame forces bit 0; stale upper bits get overwritten before completion.
    assign wr_idx   = sof ? '0 : sel;
    assign complete = din_valid && (wr_idx == idx_t'(WIDTH - 1));
    assign load     = complete && ((state == ST_EMPTY) || dout_ready);
    assign drop     = complete && !load;

    demux1x16 u_demux (
        .idx (wr_idx),
        .en  (din_valid),
        .we  (we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= '0;
            assembly <= '0;
        end else if (din_valid) begin
            sel <= wr_idx + idx_t'(1);
            for (int i = 0; i < WIDTH; i++) begin
                if (we[i]) begin
                    assembly[i] <= din;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (complete) state_nxt = ST_FULL;
            ST_FULL:  if (dout_ready && !complete) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // The completing bit bypasses the assembly register so the word is ready on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_EMPTY;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= drop;
            if (load) begin
                dout <= {din, assembly[WIDTH-2:0]};
            end
        end
    end

    assign dout_valid = (state == ST_FULL);

endmodule
